// File: rtl/hint_bit_pack_if.sv
// hint_bit_pack_if: request/result bundle for the ML-DSA HintBitPack encoder.
//  start  master->slave  begin an encode (accepted only while the encoder is idle)
//  h      master->slave  k*256 hint bits, h[i*256+j] is coefficient j of poly i, bit 0 = MSB
//  y      slave->master  omega+k byte encoding, byte b = y[8b +: 8], bit 8b = byte MSB
//  busy   slave->master  encode in progress
//  valid  slave->master  y holds a legal encoding
//  error  slave->master  last encode exceeded omega ones
//  done   slave->master  one-cycle completion pulse
interface hint_bit_pack_if #(
    parameter int K     = 8,
    parameter int OMEGA = 75
);
    logic                       start;
    logic [0:K*256-1]           h;
    logic [0:(OMEGA+K)*8-1]     y;
    logic                       busy;
    logic                       valid;
    logic                       error;
    logic                       done;
    modport master (output start, h, input y, busy, valid, error, done);
    modport slave  (input start, h, output y, busy, valid, error, done);
endinterface

// File: rtl/hint_bit_pack.sv
// hint_bit_pack: ML-DSA HintBitPack, scans k x 256 hint bits one per cycle into omega+k bytes.
//  clk  rising-edge clock
//  rst  asynchronous active-high reset; aborts any encode without a done pulse
//  bus  slave side of hint_bit_pack_if (start/h in; y/busy/valid/error/done out)
module hint_bit_pack #(
    parameter int K     = 8,
    parameter int OMEGA = 75
) (
    input logic          clk,
    input logic          rst,
    hint_bit_pack_if.slave bus
);
    localparam int NB = OMEGA + K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int YW = $clog2(NB);
    localparam logic [7:0]    OMEGA_B  = 8'(OMEGA);
    localparam logic [IW-1:0] I_LAST   = IW'(K - 1);
    localparam logic [YW-1:0] CNT_BASE = YW'(OMEGA);

    typedef enum logic [2:0] {IDLE, SCAN, STORE_LEN, DONE, ERROR} state_t;

    state_t                 state_q, state_d;
    logic [0:K-1][0:255]    h_q, h_d;
    logic [0:NB-1][7:0]     y_q, y_d;
    logic [7:0]             index_q, index_d;
    logic [7:0]             j_q, j_d;
    logic [IW-1:0]          i_q, i_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            y_q     <= '0;
            index_q <= '0;
            j_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            y_q     <= y_d;
            index_q <= index_d;
            j_q     <= j_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        y_d     = y_q;
        index_d = index_q;
        j_d     = j_q;
        i_d     = i_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        error_d = error_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    h_d     = bus.h;
                    y_d     = '0;
                    index_d = '0;
                    i_d     = '0;
                    j_d     = '0;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // j wraps to 0 naturally after 255, ready for the next poly
                j_d = j_q + 8'd1;
                if (j_q == 8'd255)
                    state_d = STORE_LEN;
                if (h_q[i_q][j_q]) begin
                    if (index_q == OMEGA_B)
                        state_d = ERROR;
                    else begin
                        y_d[YW'(index_q)] = j_q;
                        index_d           = index_q + 8'd1;
                    end
                end
            end
            STORE_LEN: begin
                y_d[CNT_BASE + YW'(i_q)] = index_q;
                if (i_q == I_LAST)
                    state_d = DONE;
                else begin
                    i_d     = i_q + IW'(1);
                    state_d = SCAN;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERROR: begin
                // zeroed so a failed encode never exposes a partial index list
                done_d  = 1'b1;
                error_d = 1'b1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                y_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.y     = y_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.error = error_q;
    assign bus.done  = done_q;
endmodule
